// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 note keyboard: scan codes, note ASCII
// values, decoder states and the frame/key-map helper functions.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] SC_KEY_A = 8'h1C;
    localparam logic [7:0] SC_KEY_W = 8'h1D;
    localparam logic [7:0] SC_KEY_Z = 8'h1A;
    localparam logic [7:0] SC_KEY_S = 8'h1B;
    localparam logic [7:0] SC_KEY_E = 8'h24;
    localparam logic [7:0] SC_KEY_X = 8'h22;
    localparam logic [7:0] SC_KEY_D = 8'h23;
    localparam logic [7:0] SC_KEY_C = 8'h21;
    localparam logic [7:0] SC_KEY_F = 8'h2B;
    localparam logic [7:0] SC_KEY_T = 8'h2C;
    localparam logic [7:0] SC_KEY_V = 8'h2A;
    localparam logic [7:0] SC_KEY_H = 8'h33;
    localparam logic [7:0] SC_KEY_U = 8'h3C;
    localparam logic [7:0] SC_KEY_B = 8'h32;
    localparam logic [7:0] SC_KEY_J = 8'h3B;
    localparam logic [7:0] SC_KEY_N = 8'h31;
    localparam logic [7:0] SC_KEY_K = 8'h42;
    localparam logic [7:0] SC_KEY_G = 8'h34;
    localparam logic [7:0] SC_KEY_Y = 8'h35;
    localparam logic [7:0] SC_KEY_M = 8'h3A;

    localparam logic [6:0] ASC_A = 7'd65;
    localparam logic [6:0] ASC_B = 7'd66;
    localparam logic [6:0] ASC_C = 7'd67;
    localparam logic [6:0] ASC_D = 7'd68;
    localparam logic [6:0] ASC_E = 7'd69;
    localparam logic [6:0] ASC_F = 7'd70;
    localparam logic [6:0] ASC_G = 7'd71;
    localparam logic [6:0] ASC_H = 7'd72;
    localparam logic [6:0] ASC_J = 7'd74;
    localparam logic [6:0] ASC_K = 7'd75;
    localparam logic [6:0] ASC_M = 7'd77;
    localparam logic [6:0] ASC_N = 7'd78;
    localparam logic [6:0] ASC_S = 7'd83;
    localparam logic [6:0] ASC_T = 7'd84;
    localparam logic [6:0] ASC_U = 7'd85;
    localparam logic [6:0] ASC_V = 7'd86;
    localparam logic [6:0] ASC_W = 7'd87;
    localparam logic [6:0] ASC_X = 7'd88;
    localparam logic [6:0] ASC_Y = 7'd89;
    localparam logic [6:0] ASC_Z = 7'd90;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

    // bits[0] = start, bits[8:1] = data, bits[9] = odd parity
    function automatic logic frame_ok(input logic [9:0] bits, input logic stop_bit);
        return (bits[0] == 1'b0) && (stop_bit == 1'b1) && ((^bits[9:1]) == 1'b1);
    endfunction

    function automatic logic [6:0] scan_to_ascii(input logic [7:0] sc);
        logic [6:0] a;
        case (sc)
            SC_KEY_A: a = ASC_A;
            SC_KEY_W: a = ASC_W;
            SC_KEY_Z: a = ASC_Z;
            SC_KEY_S: a = ASC_S;
            SC_KEY_E: a = ASC_E;
            SC_KEY_X: a = ASC_X;
            SC_KEY_D: a = ASC_D;
            SC_KEY_C: a = ASC_C;
            SC_KEY_F: a = ASC_F;
            SC_KEY_T: a = ASC_T;
            SC_KEY_V: a = ASC_V;
            SC_KEY_H: a = ASC_H;
            SC_KEY_U: a = ASC_U;
            SC_KEY_B: a = ASC_B;
            SC_KEY_J: a = ASC_J;
            SC_KEY_N: a = ASC_N;
            SC_KEY_K: a = ASC_K;
            SC_KEY_G: a = ASC_G;
            SC_KEY_Y: a = ASC_Y;
            SC_KEY_M: a = ASC_M;
            default:  a = 7'd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the raw lines, samples bits on falling
// edges, validates start/parity/stop and abandons stalled frames.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_error_q, frame_error_d;
    logic          fall_s;

    assign fall_s = clk_prev_q & ~clk_sync_q[1];

    // Two-stage synchronizers and previous-clock register for edge detect
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    // Frame state registers
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            bit_cnt_q     <= 4'd0;
            shift_q       <= 10'd0;
            tmo_q         <= '0;
            byte_q        <= 8'd0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tmo_q         <= tmo_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Bit sampling, frame check on the 11th edge, idle timeout
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        tmo_d         = tmo_q;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (fall_s) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (frame_ok(shift_q, dat_sync_q[1])) begin
                    byte_d       = shift_q[8:1];
                    byte_valid_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
            end else begin
                shift_d   = {dat_sync_q[1], shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else begin
            if (tmo_q != TMO_MAX) begin
                tmo_d = tmo_q + TW'(1);
            end else begin
                tmo_d = tmo_q;
            end
            if ((bit_cnt_q != 4'd0) && (tmo_q == TMO_LAST)) begin
                bit_cnt_d     = 4'd0;
                frame_error_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_error_o = frame_error_q;

endmodule

// File: rtl/ps2_note_keyboard.sv
// PS/2 note keyboard: prefix decoder (break/extended) turning set-2 scan
// codes into the held note's ASCII value with repeat-free strobes.
module ps2_note_keyboard
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [6:0] ascii_val,
    output logic       key_down,
    output logic       key_strobe,
    output logic       frame_error
);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic [6:0] code_s;

    dec_state_e state_q, state_d;
    logic [6:0] ascii_q, ascii_d;
    logic       key_down_q, key_down_d;
    logic       strobe_q, strobe_d;

    ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clock_i       (clock),
        .resetn_i      (resetn),
        .ps2_clk_i     (ps2_clk),
        .ps2_dat_i     (ps2_dat),
        .byte_o        (rx_byte_s),
        .byte_valid_o  (rx_valid_s),
        .frame_error_o (frame_error)
    );

    assign code_s = scan_to_ascii(rx_byte_s);

    // Decoder state and output registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ascii_q    <= 7'd0;
            key_down_q <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ascii_q    <= ascii_d;
            key_down_q <= key_down_d;
            strobe_q   <= strobe_d;
        end
    end

    // Prefix decoding; a break only clears the key currently displayed
    always_comb begin
        state_d  = state_q;
        ascii_d  = ascii_q;
        strobe_d = 1'b0;
        if (rx_valid_s) begin
            case (state_q)
                IDLE: begin
                    if (rx_byte_s == SC_BREAK) begin
                        state_d = BRK;
                    end else if (rx_byte_s == SC_EXT) begin
                        state_d = EXT;
                    end else if (code_s != 7'd0) begin
                        ascii_d  = code_s;
                        strobe_d = (code_s != ascii_q);
                    end else begin
                        ascii_d = ascii_q;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if ((code_s != 7'd0) && (code_s == ascii_q)) begin
                        ascii_d = 7'd0;
                    end else begin
                        ascii_d = ascii_q;
                    end
                end
                EXT: begin
                    if (rx_byte_s == SC_BREAK) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
        key_down_d = (ascii_d != 7'd0);
    end

    assign ascii_val  = ascii_q;
    assign key_down   = key_down_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_ps2_note_keyboard.sv
// Scoreboard bench for ps2_note_keyboard: directed PS/2 frames, expected
// strobe/error events queued at stimulus time and checked by a monitor.
module tb_ps2_note_keyboard;

    localparam int TMO  = 200;
    localparam int HALF = 20;
    localparam int GAP  = 100;

    typedef struct {
        bit         is_ferr;
        logic [6:0] val;
        int         lat;
    } ev_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [6:0] ascii_val;
    logic       key_down, key_strobe, frame_error;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_fall_cyc = 0;
    ev_t exp_q[$];
    ev_t ev;

    ps2_note_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .ascii_val   (ascii_val),
        .key_down    (key_down),
        .key_strobe  (key_strobe),
        .frame_error (frame_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every strobe or error pulse must match the head of the queue
    always @(negedge clock) begin
        if (key_strobe || frame_error) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event strobe=%0b ferr=%0b ascii=%0d", key_strobe, frame_error, ascii_val);
            end else begin
                ev = exp_q.pop_front();
                if ((ev.is_ferr != frame_error) || (ev.is_ferr == key_strobe) ||
                    (!ev.is_ferr && (ascii_val != ev.val))) begin
                    errors++;
                    $display("FAIL event got strobe=%0b ferr=%0b ascii=%0d expected ferr=%0b ascii=%0d",
                             key_strobe, frame_error, ascii_val, ev.is_ferr, ev.val);
                end
                if (ev.lat != 0) begin
                    checks++;
                    if (cyc - last_fall_cyc != ev.lat) begin
                        errors++;
                        $display("FAIL latency got %0d expected %0d", cyc - last_fall_cyc, ev.lat);
                    end
                end
            end
        end
    end

    task automatic expect_strobe(input logic [6:0] v);
        ev_t e;
        e.is_ferr = 1'b0; e.val = v; e.lat = 4;
        exp_q.push_back(e);
    endtask

    task automatic expect_ferr(input int lat);
        ev_t e;
        e.is_ferr = 1'b1; e.val = 7'd0; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b0;
            if (i == 10) last_fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (GAP) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    initial begin
        repeat (4) @(negedge clock);
        check("reset_ascii", ascii_val, 0);
        check("reset_key_down", key_down, 0);
        check("reset_strobe", key_strobe, 0);
        check("reset_ferr", frame_error, 0);
        resetn = 1'b1;
        repeat (10) @(negedge clock);

        // Press and release A
        expect_strobe(7'd65);
        send(8'h1C);
        check("press_ascii", ascii_val, 65);
        check("press_key_down", key_down, 1);
        send(8'hF0); send(8'h1C);
        check("release_ascii", ascii_val, 0);
        check("release_key_down", key_down, 0);

        // Typematic repeat of W: one strobe only
        expect_strobe(7'd87);
        send(8'h1D); send(8'h1D); send(8'h1D);
        check("typematic_ascii", ascii_val, 87);

        // Overlap: S then E, releasing S keeps E
        expect_strobe(7'd83);
        send(8'h1B);
        check("overlap_s", ascii_val, 83);
        expect_strobe(7'd69);
        send(8'h24);
        check("overlap_e", ascii_val, 69);
        send(8'hF0); send(8'h1B);
        check("overlap_keep_e", ascii_val, 69);
        send(8'hF0); send(8'h24);
        check("overlap_clear", ascii_val, 0);
        check("overlap_key_down", key_down, 0);

        // Bad parity, then a good A proves the decoder is still idle
        expect_ferr(3);
        send_frame(8'h1C, 1'b1, 11);
        check("badpar_ascii", ascii_val, 0);
        expect_strobe(7'd65);
        send(8'h1C);
        check("after_badpar_ascii", ascii_val, 65);

        // Extended and unmapped traffic while A is held
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h76);
        send(8'hE0); send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h1D);
        send(8'hAA); send(8'hFA);
        check("ext_ascii", ascii_val, 65);
        send(8'hF0); send(8'h1C);
        check("ext_clear", ascii_val, 0);

        // Truncated frame times out, next frame decodes
        expect_ferr(0);
        send_frame(8'h3A, 1'b0, 5);
        repeat (TMO + 1) @(negedge clock);
        expect_strobe(7'd77);
        send(8'h3A);
        check("after_tmo_ascii", ascii_val, 77);

        // Reset mid-frame drops everything, next frame decodes
        send_frame(8'h35, 1'b0, 5);
        resetn = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_ascii", ascii_val, 0);
        check("midrst_key_down", key_down, 0);
        resetn = 1'b1;
        repeat (TMO + 20) @(negedge clock);
        expect_strobe(7'd89);
        send(8'h35);
        check("after_rst_ascii", ascii_val, 89);
        check("after_rst_key_down", key_down, 1);

        repeat (20) @(negedge clock);
        check("pending_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
